// File: rtl/vproc_pkg.sv
// Shared types and constants for the vproc bus test engine.
// Holds the FSM and phase encodings, default address map and a saturating add.
package vproc_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, UPD_WAIT, DONE} state_t;
   typedef enum logic [1:0] {PH_WRITE, PH_READ, PH_END, PH_DONE} phase_t;

   localparam int          PAT_W         = 16;
   localparam logic [31:0] DEF_BASE_ADDR = 32'hA000_0000;
   localparam logic [31:0] DEF_END_ADDR  = 32'hB000_0000;
   localparam logic [31:0] DEF_INT_BASE  = 32'hC000_0000;

   function automatic logic [PAT_W-1:0] sat_add(input logic [PAT_W-1:0] a,
                                                 input logic [PAT_W-1:0] b);
      logic [PAT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[PAT_W] ? {PAT_W{1'b1}} : s[PAT_W-1:0];
   endfunction

endpackage

// File: rtl/vproc_irq.sv
// Interrupt edge detect, pending flags, lowest-index priority select and edge counter.
// Edges land in pending/irq_cnt one cycle after sampling; a clear and a new edge on the same bit leave it pending.
module vproc_irq
   import vproc_pkg::*;
#(
   parameter int INT_WIDTH = 3,
   parameter int IW        = 2
) (
   input  logic                 Clk,
   input  logic                 nreset,
   input  logic [INT_WIDTH-1:0] Interrupt,
   input  logic                 clr_vld,
   input  logic [IW-1:0]        clr_idx,
   output logic                 pend_any,
   output logic [IW-1:0]        pend_idx,
   output logic [PAT_W-1:0]     irq_cnt
);

   logic [INT_WIDTH-1:0] hist;
   logic [INT_WIDTH-1:0] pend;
   logic [INT_WIDTH-1:0] edges;
   logic [INT_WIDTH-1:0] clr_mask;
   logic [PAT_W-1:0]     n_edges;

   assign edges    = Interrupt & ~hist;
   assign pend_any = |pend;

   always_comb begin
      n_edges  = '0;
      clr_mask = '0;
      pend_idx = '0;
      for (int b = 0; b < INT_WIDTH; b++) begin
         n_edges     = n_edges + PAT_W'(edges[b]);
         clr_mask[b] = clr_vld && (clr_idx == IW'(b));
      end
      for (int b = INT_WIDTH - 1; b >= 0; b--) begin
         if (pend[b]) pend_idx = IW'(b);
      end
   end

   always_ff @(posedge Clk or negedge nreset) begin
      if (!nreset) begin
         hist    <= '0;
         pend    <= '0;
         irq_cnt <= '0;
      end else begin
         hist    <= Interrupt;
         pend    <= (pend & ~clr_mask) | edges;
         irq_cnt <= sat_add(irq_cnt, n_edges);
      end
   end

endmodule

// File: rtl/vproc.sv
// Single-master bus engine: writes a node/index pattern, reads it back, reports errors and interrupts.
// One access per strobe/ack handshake; next access waits for UpdateResponse to echo Update (2 cycles minimum).
module vproc
   import vproc_pkg::*;
#(
   parameter int          INT_WIDTH  = 3,
   parameter int          NODE_WIDTH = 32,
   parameter int          NUM_WORDS  = 16,
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
   parameter logic [31:0] END_ADDR   = DEF_END_ADDR,
   parameter logic [31:0] INT_BASE   = DEF_INT_BASE
) (
   input  logic                  Clk,
   input  logic                  nreset,
   output logic [31:0]           Addr,
   output logic                  WE,
   output logic                  RD,
   output logic [31:0]           DataOut,
   input  logic [31:0]           DataIn,
   input  logic                  WRAck,
   input  logic                  RDAck,
   input  logic [INT_WIDTH-1:0]  Interrupt,
   output logic                  Update,
   input  logic                  UpdateResponse,
   input  logic [NODE_WIDTH-1:0] Node
);

   localparam int IW = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;

   state_t           state;
   phase_t           phase;
   logic [PAT_W-1:0] idx;
   logic [PAT_W-1:0] err_cnt;
   logic [PAT_W-1:0] irq_cnt;
   logic             irq_svc;
   logic [IW-1:0]    svc_idx;
   logic             pend_any;
   logic [IW-1:0]    pend_idx;

   logic             nxt_none, nxt_we, nxt_rd, nxt_irq;
   logic [31:0]      nxt_addr, nxt_data, pattern;
   logic             acked, last, start_ok, node_unused;

   // Only the low half of the node ID enters the data pattern.
   assign node_unused = ^Node;
   assign pattern     = {Node[PAT_W-1:0], idx};
   assign acked       = (WE && WRAck) || (RD && RDAck);
   assign last        = (idx == PAT_W'(NUM_WORDS - 1));
   assign start_ok    = (state == IDLE) || (state == UPD_WAIT && UpdateResponse == Update);

   vproc_irq #(.INT_WIDTH(INT_WIDTH), .IW(IW)) u_irq (
      .Clk       (Clk),
      .nreset    (nreset),
      .Interrupt (Interrupt),
      .clr_vld   (state == ACCESS && RD && RDAck && irq_svc),
      .clr_idx   (svc_idx),
      .pend_any  (pend_any),
      .pend_idx  (pend_idx),
      .irq_cnt   (irq_cnt)
   );

   // Interrupt service pre-empts the program but never once the program has finished.
   always_comb begin
      nxt_none = 1'b0;
      nxt_we   = 1'b0;
      nxt_rd   = 1'b0;
      nxt_irq  = 1'b0;
      nxt_addr = BASE_ADDR + {14'd0, idx, 2'b00};
      nxt_data = '0;
      if (pend_any && phase != PH_DONE) begin
         nxt_irq  = 1'b1;
         nxt_rd   = 1'b1;
         nxt_addr = INT_BASE + {{(30 - IW){1'b0}}, pend_idx, 2'b00};
      end else begin
         case (phase)
            PH_WRITE: begin
               nxt_we   = 1'b1;
               nxt_data = pattern;
            end
            PH_READ:  nxt_rd = 1'b1;
            PH_END: begin
               nxt_we   = 1'b1;
               nxt_addr = END_ADDR;
               nxt_data = {err_cnt, irq_cnt};
            end
            default:  nxt_none = 1'b1;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         phase   <= PH_WRITE;
         idx     <= '0;
         err_cnt <= '0;
         irq_svc <= 1'b0;
         svc_idx <= '0;
         Addr    <= '0;
         DataOut <= '0;
         WE      <= 1'b0;
         RD      <= 1'b0;
         Update  <= 1'b0;
      end else begin
         case (state)
            IDLE, UPD_WAIT: begin
               if (start_ok) begin
                  if (nxt_none) begin
                     state <= DONE;
                  end else begin
                     state   <= ACCESS;
                     Addr    <= nxt_addr;
                     DataOut <= nxt_data;
                     WE      <= nxt_we;
                     RD      <= nxt_rd;
                     irq_svc <= nxt_irq;
                     svc_idx <= pend_idx;
                  end
               end
            end
            ACCESS: begin
               if (acked) begin
                  WE     <= 1'b0;
                  RD     <= 1'b0;
                  Update <= ~Update;
                  state  <= UPD_WAIT;
                  if (!irq_svc) begin
                     case (phase)
                        PH_WRITE: begin
                           idx <= last ? '0 : idx + 1'b1;
                           if (last) phase <= PH_READ;
                        end
                        PH_READ: begin
                           if (DataIn != pattern) err_cnt <= sat_add(err_cnt, 16'd1);
                           idx <= last ? '0 : idx + 1'b1;
                           if (last) phase <= PH_END;
                        end
                        PH_END:  phase <= PH_DONE;
                        default: ;
                     endcase
                  end
               end
            end
            DONE: state <= DONE;
         endcase
      end
   end

endmodule

// File: tb/tb_vproc.sv
// Directed bench for vproc: looped-back memory model, access log, per-scenario tasks.
module tb_vproc;

   logic        Clk = 1'b0;
   logic        nreset = 1'b1;
   logic [31:0] Addr, DataOut, DataIn;
   logic        WE, RD, WRAck, RDAck, Update, UpdateResponse;
   logic [2:0]  Interrupt = '0;
   logic [31:0] Node = 32'h0000_0001;

   int   wr_delay = 0;
   int   wr_cnt = 0;
   logic force_ff = 1'b0, upd_hold = 1'b0, upd_stale = 1'b0, junk_ack = 1'b0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        wr;
   } acc_t;

   acc_t        log_q[$];
   int          we_len_q[$];
   logic [31:0] mem [0:1023];
   logic        end_seen = 1'b0;
   int          upd_toggles = 0, we_run = 0, hold_bad = 0;
   logic [31:0] hold_a, hold_d;

   int checks = 0, passed = 0;

   always #5 Clk = ~Clk;

   assign DataIn         = force_ff ? 32'hFFFF_FFFF : mem[Addr[11:2]];
   assign WRAck          = (WE && (wr_cnt >= wr_delay)) || junk_ack;
   assign RDAck          = RD || junk_ack;
   assign UpdateResponse = upd_hold ? upd_stale : Update;

   vproc dut (
      .Clk            (Clk),
      .nreset         (nreset),
      .Addr           (Addr),
      .WE             (WE),
      .RD             (RD),
      .DataOut        (DataOut),
      .DataIn         (DataIn),
      .WRAck          (WRAck),
      .RDAck          (RDAck),
      .Interrupt      (Interrupt),
      .Update         (Update),
      .UpdateResponse (UpdateResponse),
      .Node           (Node)
   );

   always @(posedge Clk) wr_cnt <= WE ? wr_cnt + 1 : 0;

   always @(Update) if (nreset) upd_toggles++;

   // Bus monitor: log each completed access and track write-strobe hold lengths.
   always @(posedge Clk) begin
      acc_t e;
      if (nreset && ((WE && WRAck) || (RD && RDAck))) begin
         e.addr = Addr;
         e.data = WE ? DataOut : DataIn;
         e.wr   = WE;
         log_q.push_back(e);
         if (WE && Addr[31:28] == 4'hA) mem[Addr[11:2]] = DataOut;
         if (WE && Addr == 32'hB000_0000) end_seen = 1'b1;
      end
      if (WE) begin
         if (we_run != 0 && (Addr !== hold_a || DataOut !== hold_d)) hold_bad++;
         hold_a = Addr;
         hold_d = DataOut;
         we_run++;
      end else if (we_run != 0) begin
         we_len_q.push_back(we_run);
         we_run = 0;
      end
   end

   task automatic do_reset;
      nreset   = 1'b0;
      wr_delay = 0;
      force_ff = 1'b0;
      upd_hold = 1'b0;
      junk_ack = 1'b0;
      Interrupt = '0;
      repeat (2) @(posedge Clk);
      log_q.delete();
      we_len_q.delete();
      end_seen    = 1'b0;
      upd_toggles = 0;
      hold_bad    = 0;
      we_run      = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      @(negedge Clk);
      nreset = 1'b1;
   endtask

   task automatic run_to_end(input int budget, output int cyc);
      cyc = 0;
      for (int c = 1; c <= budget; c++) begin
         @(posedge Clk);
         #1;
         if (end_seen) begin
            cyc = c;
            break;
         end
      end
      checks++;
      if (cyc == 0) $display("FAIL end_timeout: no END write within %0d cycles", budget);
      else passed++;
   endtask

   task automatic test_reset;
      #1 nreset = 1'b0;
      #1;
      checks++; if (Addr !== 32'h0)    $display("FAIL rst_addr: got %h want 0", Addr);    else passed++;
      checks++; if (DataOut !== 32'h0) $display("FAIL rst_data: got %h want 0", DataOut); else passed++;
      checks++; if (WE !== 1'b0)       $display("FAIL rst_we: got %b want 0", WE);        else passed++;
      checks++; if (RD !== 1'b0)       $display("FAIL rst_rd: got %b want 0", RD);        else passed++;
      checks++; if (Update !== 1'b0)   $display("FAIL rst_upd: got %b want 0", Update);   else passed++;
   endtask

   task automatic test_program;
      int cyc;
      logic [31:0] ea, ed;
      logic        ew;
      do_reset();
      run_to_end(200, cyc);
      checks++; if (cyc != 66) $display("FAIL prog_cycles: got %0d want 66", cyc); else passed++;
      repeat (6) @(posedge Clk);
      #1;
      checks++; if (log_q.size() != 33) $display("FAIL prog_count: got %0d want 33", log_q.size()); else passed++;
      for (int i = 0; i < 33 && i < log_q.size(); i++) begin
         if (i < 32) begin
            ea = 32'hA000_0000 + 32'(4 * (i % 16));
            ed = 32'h0001_0000 + 32'(i % 16);
            ew = (i < 16);
         end else begin
            ea = 32'hB000_0000;
            ed = 32'h0000_0000;
            ew = 1'b1;
         end
         checks++;
         if (log_q[i].addr !== ea || log_q[i].data !== ed || log_q[i].wr !== ew)
            $display("FAIL prog_acc%0d: got %h/%h/wr%b want %h/%h/wr%b",
                     i, log_q[i].addr, log_q[i].data, log_q[i].wr, ea, ed, ew);
         else passed++;
      end
      checks++; if (upd_toggles != 33) $display("FAIL prog_toggles: got %0d want 33", upd_toggles); else passed++;
      checks++; if (WE !== 1'b0 || RD !== 1'b0) $display("FAIL prog_done_idle: got WE%b RD%b want 00", WE, RD); else passed++;
   endtask

   task automatic test_bad_data;
      int cyc;
      do_reset();
      force_ff = 1'b1;
      run_to_end(200, cyc);
      checks++;
      if (log_q.size() != 33 || log_q[log_q.size()-1].data !== 32'h0010_0000)
         $display("FAIL err_end_data: got %h (n=%0d) want 00100000",
                  log_q[log_q.size()-1].data, log_q.size());
      else passed++;
   endtask

   task automatic test_wr_delay;
      int cyc, bad;
      do_reset();
      wr_delay = 3;
      run_to_end(400, cyc);
      repeat (4) @(posedge Clk);
      #1;
      bad = 0;
      foreach (we_len_q[i]) if (we_len_q[i] != 4) bad++;
      checks++; if (we_len_q.size() != 17 || bad != 0)
         $display("FAIL dly_hold_len: got %0d runs, %0d not 4 cycles; want 17 runs all 4", we_len_q.size(), bad);
      else passed++;
      checks++; if (hold_bad != 0) $display("FAIL dly_stable: got %0d changes want 0", hold_bad); else passed++;
      checks++; if (log_q.size() != 33) $display("FAIL dly_count: got %0d want 33", log_q.size()); else passed++;
      checks++; if (upd_toggles != 33) $display("FAIL dly_toggles: got %0d want 33", upd_toggles); else passed++;
      checks++; if (log_q[log_q.size()-1].data !== 32'h0) $display("FAIL dly_end_data: got %h want 0", log_q[log_q.size()-1].data); else passed++;
   endtask

   task automatic test_irq;
      int cyc, nirq;
      logic found;
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge Clk);
         if (WE && log_q.size() == 5) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (!found) $display("FAIL irq_sync: got no 6th write strobe want one"); else passed++;
      Interrupt = 3'b010;
      @(negedge Clk);
      Interrupt = 3'b000;
      run_to_end(200, cyc);
      checks++; if (log_q.size() != 34) $display("FAIL irq_count: got %0d want 34", log_q.size()); else passed++;
      if (log_q.size() >= 8) begin
         checks++; if (log_q[6].addr !== 32'hC000_0004 || log_q[6].wr !== 1'b0)
            $display("FAIL irq_svc_read: got %h wr%b want c0000004 wr0", log_q[6].addr, log_q[6].wr);
         else passed++;
         checks++; if (log_q[7].addr !== 32'hA000_0018 || log_q[7].data !== 32'h0001_0006)
            $display("FAIL irq_resume: got %h/%h want a0000018/00010006", log_q[7].addr, log_q[7].data);
         else passed++;
      end
      nirq = 0;
      foreach (log_q[i]) if (log_q[i].addr[31:28] == 4'hC) nirq++;
      checks++; if (nirq != 1) $display("FAIL irq_once: got %0d service reads want 1", nirq); else passed++;
      checks++; if (log_q[log_q.size()-1].data !== 32'h0000_0001)
         $display("FAIL irq_end_data: got %h want 00000001", log_q[log_q.size()-1].data);
      else passed++;
   endtask

   task automatic test_upd_hold;
      int cyc, strobe_bad;
      logic found;
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge Clk);
         if (WE && log_q.size() == 3) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (!found) $display("FAIL hold_sync: got no 4th write strobe want one"); else passed++;
      upd_stale = Update;
      upd_hold  = 1'b1;
      strobe_bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         junk_ack = 1'b1;
         if (WE || RD) strobe_bad++;
      end
      checks++; if (strobe_bad != 0) $display("FAIL hold_no_strobe: got %0d strobe cycles want 0", strobe_bad); else passed++;
      checks++; if (upd_toggles != 4) $display("FAIL hold_toggles: got %0d want 4", upd_toggles); else passed++;
      upd_hold = 1'b0;
      junk_ack = 1'b0;
      @(posedge Clk);
      #1;
      checks++; if (WE !== 1'b1 || Addr !== 32'hA000_0010)
         $display("FAIL hold_resume: got WE%b %h want WE1 a0000010", WE, Addr);
      else passed++;
      run_to_end(200, cyc);
      checks++; if (log_q.size() != 33 || log_q[log_q.size()-1].data !== 32'h0)
         $display("FAIL hold_end: got n=%0d data %h want 33/00000000", log_q.size(), log_q[log_q.size()-1].data);
      else passed++;
   endtask

   task automatic test_reset_mid;
      logic found;
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge Clk);
         if (RD) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (!found) $display("FAIL mid_sync: got no read strobe want one"); else passed++;
      #2 nreset = 1'b0;
      #1;
      checks++; if (RD !== 1'b0 || Addr !== 32'h0) $display("FAIL mid_async: got RD%b %h want RD0 0", RD, Addr); else passed++;
      do_reset();
      for (int c = 0; c < 20 && log_q.size() == 0; c++) @(posedge Clk);
      #1;
      checks++; if (log_q.size() == 0 || log_q[0].addr !== 32'hA000_0000 || log_q[0].data !== 32'h0001_0000 || log_q[0].wr !== 1'b1)
         $display("FAIL mid_restart: got n=%0d first %h/%h want a0000000/00010000 write",
                  log_q.size(), log_q.size() ? log_q[0].addr : 32'h0, log_q.size() ? log_q[0].data : 32'h0);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_program();
      test_bad_data();
      test_wr_delay();
      test_irq();
      test_upd_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vproc.md
VPROC -- requirements
Module: vproc

Interface
REQ-001 SHALL have parameters: INT_WIDTH, default 3, interrupt vector width; NODE_WIDTH, default 32, node-ID width; NUM_WORDS, default 16, test-program length in words (1..1024); BASE_ADDR, default 32'hA000_0000, program base; END_ADDR, default 32'hB000_0000, completion address; INT_BASE, default 32'hC000_0000, interrupt-service base.
REQ-002 SHALL have ports: Clk in 1, sole clock, rising edge; nreset in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: Addr out 32, byte address; WE out 1, write strobe; RD out 1, read strobe; DataOut out 32, write data.
REQ-004 SHALL have ports: DataIn in 32, read data; WRAck in 1, write acknowledge; RDAck in 1, read acknowledge.
REQ-005 SHALL have ports: Interrupt in INT_WIDTH, level interrupt vector; Update out 1, toggle-per-access strobe; UpdateResponse in 1, update echo.
REQ-006 SHALL have port: Node in NODE_WIDTH, static node ID.
REQ-007 SHALL omit burst ports.

Function
REQ-008 SHALL act as a single-master bus engine running a fixed test program: phase WRITE, then READ, then END, then DONE.
REQ-009 WRITE phase: for i = 0..NUM_WORDS-1, write Addr = BASE_ADDR + 4*i, DataOut = {Node[15:0], i[15:0]}.
REQ-010 READ phase: read the same addresses in the same order; compare DataIn against the WRITE pattern; increment a 16-bit saturating error count on each mismatch.
REQ-011 END phase: one write, Addr = END_ADDR, DataOut = {err_cnt[15:0], irq_cnt[15:0]}.
REQ-012 DONE: no further accesses; only interrupt counting continues.
REQ-013 Access start: WE or RD (never both) SHALL be registered high together with Addr and DataOut.
REQ-014 Access hold: the strobe, Addr and DataOut SHALL stay stable until a rising edge samples the matching ack high.
REQ-015 Ack with strobe: at that edge the strobe SHALL drop, Update SHALL toggle, and on a read DataIn SHALL be captured.
REQ-016 Ack without strobe: WRAck/RDAck sampled while the matching strobe is low SHALL be ignored.
REQ-017 After Update toggles, no new access SHALL start until UpdateResponse == Update is sampled; at that edge the next access SHALL start.
REQ-018 With acks tied to strobes and UpdateResponse tied to Update, each access SHALL occupy exactly 2 cycles: strobe 1 cycle, then 1 gap cycle.
REQ-019 A rising edge on any Interrupt bit (vs the previous sample) SHALL set that bit's pending flag and increment the 16-bit saturating irq_cnt.
REQ-020 Between accesses, in the cycle the next access would start, the lowest-numbered pending bit k SHALL be serviced first by a read of INT_BASE + 4*k, with data discarded and no compare.
REQ-021 The pending flag for k SHALL clear at that read's ack.
REQ-022 The program position SHALL resume unchanged after interrupt service.
REQ-023 A new edge on a bit already pending SHALL still be counted but SHALL not queue twice.
REQ-024 FSM states: IDLE, ACCESS, UPD_WAIT, DONE; the phase and index SHALL be held in separate registers.
REQ-025 IDLE SHALL move to ACCESS on the first clock after reset release.

Reset
REQ-026 While nreset is low: Addr = 0, DataOut = 0, WE = 0, RD = 0, Update = 0.
REQ-027 While nreset is low: index, err_cnt, irq_cnt, pending flags and the interrupt history SHALL be 0; phase = WRITE; state = IDLE.
REQ-028 Reset asserted mid-access SHALL drop strobes immediately (asynchronous) and abandon the access.
REQ-029 After reset release the program SHALL restart from i = 0.

Structure
REQ-030 A shared package SHALL hold the state and phase enumerations, the default address constants and the data-pattern width (16).
REQ-031 One sub-module, vproc_irq, SHALL provide edge detection, pending flags, priority select and irq_cnt.
REQ-032 The rest SHALL be a single sequencer with registered outputs; no combinational path from any input to any output.

Verification
REQ-033 Node = 1, NUM_WORDS = 16, 1K-word memory at segment 0xA, acks and Update looped back -> writes 0xA000_0000/0x0001_0000 through 0xA000_003C/0x0001_000F, then 16 reads; END write to 0xB000_0000 with data 0x0000_0000; total 33 accesses in 66 cycles.
REQ-034 Same setup with DataIn forced to 0xFFFF_FFFF -> END data 0x0010_0000.
REQ-035 WRAck delayed 3 cycles after WE -> WE, Addr and DataOut held 4 cycles; Update toggles once per access; no access lost.
REQ-036 One-cycle pulse on Interrupt[1] during the WRITE phase -> the next access is a read of 0xC000_0004, the program continues at the next index, and END data low half = 0x0001.
REQ-037 UpdateResponse held for 5 cycles -> no strobe during the wait; the access starts on the edge equality is sampled.
REQ-038 nreset pulled low while RD is high -> RD drops without a clock; after release the first access is a write of 0xA000_0000.
